flappy_tick_gen: RTL and testbench
==================================

# flappy_tick_gen

Parametrised timing block for Flappy-VGA that replaces bit-tap derived clocks with single-cycle clock-enable strobes on one system clock. It drives NUM_CH independent programmable-period tick channels and a 7-segment scan index. Channel 0, the game-pace channel, speeds up in discrete levels as the score crosses multiples of LEVEL_STEP. It sits beside the top level and feeds enables to the bird/pipe logic, the move animator, the VGA pixel pipeline and the segment driver.

## Interface
- NUM_CH, 4: number of tick channels (≥1); channel 0 is score-scaled.
- CNT_W, 32: width of each period value and down-counter.
- SCORE_W, 8: score input width.
- LEVEL_STEP, 5: score points per speed level (≥1).
- MAX_LEVEL, 4: saturating level limit (< CNT_W).
- SCAN_W, 2: width of the segment scan index.
- SCAN_SHIFT, 18: log2 of cycles per scan step.
- Clock and reset are decided: one clock; reset is asynchronous and active-low.
- clk  in  1  system clock; the only clock.
- rst_n  in  1  async assert, active-low reset; deassertion is synchronous to clk upstream.
- period_i  in  NUM_CH*CNT_W  per-channel base period in cycles; channel k is at bits [k*CNT_W +: CNT_W].
- en_i  in  NUM_CH  per-channel run enable.
- score_i  in  SCORE_W  current game score (binary).
- restart_i  in  1  one-cycle game restart pulse.
- tick_o  out  NUM_CH  one-cycle strobes.
- level_o  out  $clog2(MAX_LEVEL+1)  current speed level.
- scan_o  out  SCAN_W  segment digit index.

## Operation
- Each channel has a down-counter cnt[k]. After reset, cnt[k] = 0.
- Cycle with en_i[k]=1 and cnt[k]==0:
  - tick_o[k] is 1 next cycle.
  - cnt[k] reloads to eff[k]−1.
- Cycle with en_i[k]=1 and cnt[k]≠0: decrement cnt[k]; no tick.
- en_i[k]=0: cnt[k] holds; no tick.
- Effective period: eff[k] = period_i[k] for k>0; eff[0] = period_i[0] >> level.
- Any eff ≤ 1 (including 0) means a tick every enabled cycle.
- Period or level changes take effect only at the next reload; the current count is never truncated.
- Level FSM uses registers level and thresh, with no divider:
  - Reset or restart_i: level=0, thresh=LEVEL_STEP.
  - Else if score_i ≥ thresh and level < MAX_LEVEL: level+1, thresh+LEVEL_STEP.
  - At most one level step per cycle; a score jump across several thresholds climbs over consecutive cycles.
  - Level never decreases except on restart_i or reset. It saturates at MAX_LEVEL.
  - thresh is SCORE_W+1 bits, so it cannot wrap.
- restart_i also zeroes every cnt[k], so the first tick after release is aligned.
  - restart_i overrides a same-cycle reload and a same-cycle level step.
- Scan: free-running counter scnt, SCAN_SHIFT+SCAN_W bits; scan_o = scnt[top SCAN_W bits].
  - scnt wraps modulo 2^(SCAN_SHIFT+SCAN_W) and is not affected by restart_i.

## Timing
- Reset values: tick_o=0, level_o=0, scan_o=0, all counters 0.
- All outputs are registered. Latency:
  - en_i → first tick_o: 1 cycle (the counter starts at 0).
  - score_i crossing → level_o: 1 cycle.
  - level_o change → period change: effective from the next channel-0 reload.
- Steady state: tick_o[k] is high exactly 1 of every eff[k] enabled cycles.
- Reset asserted mid-count: all state clears immediately and asynchronously; no partial tick.

## Structure
- Package flappy_clk_pkg holds:
  - Default constants (LEVEL_STEP, MAX_LEVEL, SCAN_SHIFT).
  - Channel index constants CH_GAME=0, CH_MOVE=1, CH_PACE=2, CH_VGA=3.
- Sub-module flappy_tick_chan: one down-counter, reload and tick register. It is instanced via generate for each channel.
- The level FSM and scan counter stay in the top.

## Test plan
- Reset, then en_i=4'b1111 with periods {4,8,3,1} (channel 0 = 4): tick_o[0] at cycles 1,5,9; tick_o[3] every cycle; tick_o[2] every 3rd cycle.
- period_i[0]=32; score_i stepped 0→5→10→15→20→25: level_o goes 1,2,3,4 and stays 4 at 25; channel-0 spacing goes 32→16→8→4→2 after each reload.
- score_i jumps 0→17 in one cycle: level_o goes 1,2,3 on three consecutive cycles; restart_i then gives level_o=0 and a channel-0 tick 1 cycle later.
- en_i[1] dropped mid-count for 10 cycles with period 8: the tick is delayed by exactly 10 cycles and no tick occurs while disabled.
- Periods 0 and 1: a tick every cycle. Change period 16→4 mid-count: the old interval completes, then 4-cycle spacing.
- SCAN_SHIFT=2, SCAN_W=2: scan_o sequence 0,1,2,3,0 changing every 4 cycles; rst_n pulsed mid-run forces all outputs to 0 asynchronously.

Source files
------------

// File: rtl/flappy_clk_pkg.sv
// Shared constants for the Flappy-VGA tick generator: default pacing values
// and the channel map used by the consumers of tick_o.
package flappy_clk_pkg;

  localparam int DEF_LEVEL_STEP = 5;
  localparam int DEF_MAX_LEVEL  = 4;
  localparam int DEF_SCAN_SHIFT = 18;

  typedef enum logic [1:0] {
    CH_GAME = 2'd0,
    CH_MOVE = 2'd1,
    CH_PACE = 2'd2,
    CH_VGA  = 2'd3
  } chan_e;

endpackage

// File: rtl/flappy_tick_chan.sv
// One programmable-period tick channel: down-counter with reload on terminal
// count and a registered single-cycle tick strobe.
module flappy_tick_chan #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             restart,
  input  logic [CNT_W-1:0] eff,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] reload;

  // Periods of 0 and 1 both collapse to "tick on every enabled cycle".
  assign reload = (eff <= CNT_W'(1)) ? '0 : eff - 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (en) begin
      if (cnt == '0) begin
        cnt  <= reload;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt - 1'b1;
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/flappy_tick_gen.sv
// Clock-enable generator for Flappy-VGA: NUM_CH tick channels, a score-driven
// speed level that shortens the game-pace period, and a 7-segment scan index.
//   level       | meaning
//   0           | game channel runs at its base period
//   1..MAX-1    | game period is base >> level; climbs when score >= thresh
//   MAX_LEVEL   | saturated; only restart or reset return to 0
module flappy_tick_gen
  import flappy_clk_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 32,
  parameter int SCORE_W    = 8,
  parameter int LEVEL_STEP = DEF_LEVEL_STEP,
  parameter int MAX_LEVEL  = DEF_MAX_LEVEL,
  parameter int SCAN_W     = 2,
  parameter int SCAN_SHIFT = DEF_SCAN_SHIFT,
  localparam int LVL_W     = $clog2(MAX_LEVEL + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*CNT_W-1:0] period_i,
  input  logic [NUM_CH-1:0]       en_i,
  input  logic [SCORE_W-1:0]      score_i,
  input  logic                    restart_i,
  output logic [NUM_CH-1:0]       tick_o,
  output logic [LVL_W-1:0]        level_o,
  output logic [SCAN_W-1:0]       scan_o
);

  localparam int TH_W = SCORE_W + 1;
  localparam int SC_W = SCAN_SHIFT + SCAN_W;
  localparam logic [TH_W-1:0]  STEP_TH = TH_W'(LEVEL_STEP);
  localparam logic [LVL_W-1:0] MAX_LVL = LVL_W'(MAX_LEVEL);

  logic [LVL_W-1:0]               level_q;
  logic [TH_W-1:0]                thresh_q;
  logic [SC_W-1:0]                scnt;
  logic [NUM_CH-1:0][CNT_W-1:0]   eff;

  // Threshold tracks the next score boundary, so no divider is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q  <= '0;
      thresh_q <= STEP_TH;
    end else if (restart_i) begin
      level_q  <= '0;
      thresh_q <= STEP_TH;
    end else if (({1'b0, score_i} >= thresh_q) && (level_q < MAX_LVL)) begin
      level_q  <= level_q + 1'b1;
      thresh_q <= thresh_q + STEP_TH;
    end
  end

  assign level_o = level_q;

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      eff[k] = period_i[k*CNT_W +: CNT_W];
    end
    eff[int'(CH_GAME)] = period_i[CNT_W-1:0] >> level_q;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    flappy_tick_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en_i[k]),
      .restart (restart_i),
      .eff     (eff[k]),
      .tick    (tick_o[k])
    );
  end

  // Scan counter free-runs through restarts so the display never stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt <= '0;
    end else begin
      scnt <= scnt + 1'b1;
    end
  end

  assign scan_o = scnt[SC_W-1 -: SCAN_W];

endmodule

// File: tb/tb_flappy_tick_gen.sv
// Bench for flappy_tick_gen: interval-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_flappy_tick_gen;

  localparam int NUM_CH     = 4;
  localparam int CNT_W      = 32;
  localparam int SCORE_W    = 8;
  localparam int LEVEL_STEP = 5;
  localparam int MAX_LEVEL  = 4;
  localparam int SCAN_W     = 2;
  localparam int SCAN_SHIFT = 2;
  localparam int LVL_W      = $clog2(MAX_LEVEL + 1);

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NUM_CH*CNT_W-1:0] period_i = '0;
  logic [NUM_CH-1:0]       en_i = '0;
  logic [SCORE_W-1:0]      score_i = '0;
  logic                    restart_i = 1'b0;
  logic [NUM_CH-1:0]       tick_o;
  logic [LVL_W-1:0]        level_o;
  logic [SCAN_W-1:0]       scan_o;

  int checks = 0;
  int failures = 0;
  bit mon_on = 1'b0;

  flappy_tick_gen #(
    .NUM_CH     (NUM_CH),
    .CNT_W      (CNT_W),
    .SCORE_W    (SCORE_W),
    .LEVEL_STEP (LEVEL_STEP),
    .MAX_LEVEL  (MAX_LEVEL),
    .SCAN_W     (SCAN_W),
    .SCAN_SHIFT (SCAN_SHIFT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .period_i  (period_i),
    .en_i      (en_i),
    .score_i   (score_i),
    .restart_i (restart_i),
    .tick_o    (tick_o),
    .level_o   (level_o),
    .scan_o    (scan_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a channel fires when the enabled cycles since its last
  // tick reach the interval latched at that tick; level chases score/STEP.
  longint            m_since [NUM_CH];
  longint            m_gap   [NUM_CH];
  logic [NUM_CH-1:0] m_tick = '0;
  int                m_level = 0;
  longint            m_cyc = 0;

  function automatic longint eff_of(input int ch, input int lvl);
    longint p;
    p = longint'(period_i[ch*CNT_W +: CNT_W]);
    if (ch == 0) p = p >> lvl;
    return (p < 1) ? 1 : p;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int tgt;
    if (!rst_n) begin
      m_tick  = '0;
      m_level = 0;
      m_cyc   = 0;
      for (int k = 0; k < NUM_CH; k++) begin
        m_since[k] = 0;
        m_gap[k]   = 0;
      end
    end else begin
      m_cyc++;
      if (restart_i) begin
        m_tick  = '0;
        m_level = 0;
        for (int k = 0; k < NUM_CH; k++) begin
          m_since[k] = 0;
          m_gap[k]   = 0;
        end
      end else begin
        for (int k = 0; k < NUM_CH; k++) begin
          m_tick[k] = 1'b0;
          if (en_i[k]) begin
            if (m_since[k] >= m_gap[k]) begin
              m_tick[k]  = 1'b1;
              m_gap[k]   = eff_of(k, m_level);
              m_since[k] = 1;
            end else begin
              m_since[k]++;
            end
          end
        end
        tgt = int'(score_i) / LEVEL_STEP;
        if (tgt > MAX_LEVEL) tgt = MAX_LEVEL;
        if (m_level < tgt) m_level++;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      check("model_tick", longint'(tick_o), longint'(m_tick));
      check("model_level", longint'(level_o), longint'(m_level));
      check("model_scan", longint'(scan_o), (m_cyc >> SCAN_SHIFT) % (1 << SCAN_W));
    end
  end

  task automatic set_period(input int ch, input int p);
    period_i[ch*CNT_W +: CNT_W] = CNT_W'(p);
  endtask

  task automatic pulse_restart();
    restart_i = 1'b1;
    @(negedge clk);
    restart_i = 1'b0;
  endtask

  // Counts cycles until tick_o[ch] is seen; a timeout is a failed comparison.
  task automatic count_to_tick(input int ch, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick_o[ch] && n < 200);
    if (!tick_o[ch]) begin
      checks++;
      failures++;
      $display("FAIL tick_timeout ch=%0d actual=none required=tick within 200 cycles", ch);
    end
  endtask

  logic [8:0] h0, h1, h2, h3;
  int n, g, saw;
  int lvl_tab [5] = '{1, 2, 3, 4, 4};
  int gap_tab [5] = '{16, 8, 4, 2, 2};

  initial begin
    repeat (3) @(negedge clk);
    mon_on = 1'b1;
    check("reset_tick", longint'(tick_o), 0);
    check("reset_level", longint'(level_o), 0);
    check("reset_scan", longint'(scan_o), 0);
    set_period(0, 4);
    set_period(1, 8);
    set_period(2, 3);
    set_period(3, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Base periods {4,8,3,1}, all channels enabled from zero counts.
    en_i = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      h0[i] = tick_o[0];
      h1[i] = tick_o[1];
      h2[i] = tick_o[2];
      h3[i] = tick_o[3];
    end
    check("ch0_pattern_p4", longint'(h0), longint'(9'b100010001));
    check("ch1_pattern_p8", longint'(h1), longint'(9'b100000001));
    check("ch2_pattern_p3", longint'(h2), longint'(9'b001001001));
    check("ch3_pattern_p1", longint'(h3), longint'(9'b111111111));

    // Score jump across three thresholds climbs one level per cycle.
    score_i = 8'd0;
    pulse_restart();
    score_i = 8'd17;
    @(negedge clk); check("jump_level_1", longint'(level_o), 1);
    @(negedge clk); check("jump_level_2", longint'(level_o), 2);
    @(negedge clk); check("jump_level_3", longint'(level_o), 3);
    @(negedge clk); check("jump_level_hold", longint'(level_o), 3);
    score_i = 8'd0;
    restart_i = 1'b1;
    @(negedge clk);
    restart_i = 1'b0;
    check("restart_level", longint'(level_o), 0);
    check("restart_no_tick", longint'(tick_o[0]), 0);
    @(negedge clk);
    check("restart_first_tick", longint'(tick_o[0]), 1);

    // Score-scaled spacing on the game channel.
    set_period(0, 32);
    score_i = 8'd0;
    pulse_restart();
    count_to_tick(0, n);
    count_to_tick(0, g);
    check("gap_level0", g, 32);
    for (int i = 0; i < 5; i++) begin
      score_i = SCORE_W'((i + 1) * 5);
      repeat (2) @(negedge clk);
      check("step_level", longint'(level_o), lvl_tab[i]);
      count_to_tick(0, n);
      count_to_tick(0, g);
      check("step_gap", g, gap_tab[i]);
    end

    // Disable window on channel 1 delays its tick by exactly the window.
    score_i = 8'd0;
    set_period(1, 8);
    pulse_restart();
    count_to_tick(1, n);
    repeat (3) @(negedge clk);
    en_i[1] = 1'b0;
    saw = 0;
    repeat (10) begin
      @(negedge clk);
      if (tick_o[1]) saw++;
    end
    en_i[1] = 1'b1;
    count_to_tick(1, n);
    check("disabled_no_tick", saw, 0);
    check("disabled_delay", 3 + 10 + n, 18);

    // Periods 0 and 1 both tick every cycle.
    set_period(2, 0);
    set_period(3, 1);
    pulse_restart();
    h2 = '0;
    h3 = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      h2[i] = tick_o[2];
      h3[i] = tick_o[3];
    end
    check("period0_every", longint'(h2), longint'(9'h0FF));
    check("period1_every", longint'(h3), longint'(9'h0FF));

    // A mid-count period change waits for the running interval to finish.
    set_period(1, 16);
    pulse_restart();
    count_to_tick(1, n);
    saw = 0;
    repeat (5) begin
      @(negedge clk);
      if (tick_o[1]) saw++;
    end
    set_period(1, 4);
    count_to_tick(1, n);
    check("change_no_early", saw, 0);
    check("change_old_interval", 5 + n, 16);
    count_to_tick(1, g);
    check("change_new_interval", g, 4);

    // Asynchronous reset mid-run, then the scan sequence from zero.
    score_i = 8'd20;
    repeat (6) @(negedge clk);
    check("pre_reset_level", longint'(level_o), 4);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_tick", longint'(tick_o), 0);
    check("async_level", longint'(level_o), 0);
    check("async_scan", longint'(scan_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 3)  check("scan_at3", longint'(scan_o), 0);
      if (i == 4)  check("scan_at4", longint'(scan_o), 1);
      if (i == 8)  check("scan_at8", longint'(scan_o), 2);
      if (i == 12) check("scan_at12", longint'(scan_o), 3);
      if (i == 16) check("scan_at16", longint'(scan_o), 0);
    end

    mon_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
